// File: rtl/if_pcgen.sv
// IFU fetch-control stage: owns the PC, issues one fetch at a time, fills the IR
// and the decode buffer, and steers the next PC from BPU results or EXU flushes.
module if_pcgen #(
   parameter int                 PC_SIZE  = 32,
   parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic               clk,
   input  logic               rst,

   output logic               ifu_req_valid,
   input  logic               ifu_req_ready,
   output logic [PC_SIZE-1:0] ifu_req_pc,

   input  logic               ifu_rsp_valid,
   output logic               ifu_rsp_ready,
   input  logic [31:0]        ifu_rsp_instr,
   input  logic               ifu_rsp_err,

   output logic               dec_i_valid,
   output logic [31:0]        dec_instr,
   output logic [PC_SIZE-1:0] dec_pc,
   input  logic               dec_rv32,

   input  logic               pred_taken,
   input  logic               bpu_wait,
   input  logic [PC_SIZE-1:0] bpu_op1,
   input  logic [PC_SIZE-1:0] bpu_op2,

   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [31:0]        ir_instr,
   output logic [PC_SIZE-1:0] ir_pc,
   output logic               ir_err,

   input  logic               pipe_flush_req,
   input  logic [PC_SIZE-1:0] pipe_flush_pc,
   output logic               pipe_flush_ack
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DECODE   = 2'd3
   } state_t;

   localparam logic [PC_SIZE-1:0] PC_INC2 = PC_SIZE'(2);
   localparam logic [PC_SIZE-1:0] PC_INC4 = PC_SIZE'(4);

   state_t               state_reg, state_next;
   logic [PC_SIZE-1:0]   pc_reg, pc_next;
   logic                 ir_valid_reg, ir_valid_next;
   logic [31:0]          ir_instr_reg, ir_instr_next;
   logic [PC_SIZE-1:0]   ir_pc_reg, ir_pc_next;
   logic                 ir_err_reg, ir_err_next;
   logic [31:0]          dec_instr_reg, dec_instr_next;
   logic [PC_SIZE-1:0]   dec_pc_reg, dec_pc_next;
   logic                 dec_err_reg, dec_err_next;

   logic [PC_SIZE-1:0]   taken_sum;
   logic [PC_SIZE-1:0]   taken_pc;
   logic [PC_SIZE-1:0]   seq_pc;
   logic [PC_SIZE-1:0]   next_pc;
   logic                 rsp_fire;
   logic                 flush_take;

   // A faulting fetch cannot be trusted for length or prediction: step by a full word.
   always_comb begin
      taken_sum = bpu_op1 + bpu_op2;
      taken_pc  = {taken_sum[PC_SIZE-1:1], 1'b0};
      seq_pc    = dec_pc_reg + (dec_rv32 ? PC_INC4 : PC_INC2);
      if (dec_err_reg) begin
         next_pc = dec_pc_reg + PC_INC4;
      end else if (pred_taken) begin
         next_pc = taken_pc;
      end else begin
         next_pc = seq_pc;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      ir_valid_next  = ir_valid_reg;
      ir_instr_next  = ir_instr_reg;
      ir_pc_next     = ir_pc_reg;
      ir_err_next    = ir_err_reg;
      dec_instr_next = dec_instr_reg;
      dec_pc_next    = dec_pc_reg;
      dec_err_next   = dec_err_reg;
      ifu_req_valid  = 1'b0;
      ifu_rsp_ready  = 1'b0;
      dec_i_valid    = 1'b0;
      pipe_flush_ack = 1'b0;
      rsp_fire       = 1'b0;
      flush_take     = 1'b0;

      if (ir_valid_reg && ir_ready) begin
         ir_valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            state_next = REQ;
            flush_take = pipe_flush_req;
         end
         REQ: begin
            ifu_req_valid = ~pipe_flush_req;
            flush_take    = pipe_flush_req;
            if (ifu_req_ready && !pipe_flush_req) begin
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            // A pending flush drains the outstanding response regardless of IR space.
            ifu_rsp_ready = pipe_flush_req | ~ir_valid_reg | ir_ready;
            rsp_fire      = ifu_rsp_valid & ifu_rsp_ready;
            flush_take    = pipe_flush_req & rsp_fire;
            if (rsp_fire && !pipe_flush_req) begin
               ir_valid_next  = 1'b1;
               ir_instr_next  = ifu_rsp_instr;
               ir_pc_next     = pc_reg;
               ir_err_next    = ifu_rsp_err;
               dec_instr_next = ifu_rsp_instr;
               dec_pc_next    = pc_reg;
               dec_err_next   = ifu_rsp_err;
               state_next     = DECODE;
            end
         end
         DECODE: begin
            dec_i_valid = 1'b1;
            flush_take  = pipe_flush_req;
            if (!bpu_wait) begin
               pc_next    = next_pc;
               state_next = REQ;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Redirect overrides whatever the current state decided above.
      if (flush_take) begin
         pipe_flush_ack = 1'b1;
         pc_next        = pipe_flush_pc;
         ir_valid_next  = 1'b0;
         state_next     = REQ;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         ir_valid_reg  <= 1'b0;
         ir_instr_reg  <= '0;
         ir_pc_reg     <= '0;
         ir_err_reg    <= 1'b0;
         dec_instr_reg <= '0;
         dec_pc_reg    <= '0;
         dec_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         ir_valid_reg  <= ir_valid_next;
         ir_instr_reg  <= ir_instr_next;
         ir_pc_reg     <= ir_pc_next;
         ir_err_reg    <= ir_err_next;
         dec_instr_reg <= dec_instr_next;
         dec_pc_reg    <= dec_pc_next;
         dec_err_reg   <= dec_err_next;
      end
   end

   assign ifu_req_pc = pc_reg;
   assign dec_instr  = dec_instr_reg;
   assign dec_pc     = dec_pc_reg;
   assign ir_valid   = ir_valid_reg;
   assign ir_instr   = ir_instr_reg;
   assign ir_pc      = ir_pc_reg;
   assign ir_err     = ir_err_reg;

endmodule

// File: tb/tb_if_pcgen.sv
// Directed bench for if_pcgen: sequential/branch PC steering, BPU stalls,
// IR backpressure, flush in every state and asynchronous reset.
module tb_if_pcgen;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_pc;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_ready;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_rsp_err;
   logic        dec_i_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        dec_rv32;
   logic        pred_taken;
   logic        bpu_wait;
   logic [31:0] bpu_op1;
   logic [31:0] bpu_op2;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir_instr;
   logic [31:0] ir_pc;
   logic        ir_err;
   logic        pipe_flush_req;
   logic [31:0] pipe_flush_pc;
   logic        pipe_flush_ack;

   int n_cmp = 0;
   int n_err = 0;

   if_pcgen #(.PC_SIZE(32), .RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
      .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
      .dec_i_valid(dec_i_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_rv32(dec_rv32),
      .pred_taken(pred_taken), .bpu_wait(bpu_wait), .bpu_op1(bpu_op1), .bpu_op2(bpu_op2),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc), .ir_err(ir_err),
      .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered and left at a negedge with the DUT in REQ.
   task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] instr,
                            input logic rv32, input logic pt, input logic err,
                            input logic [31:0] op1, input logic [31:0] op2, input int waits);
      ifu_req_ready = 1'b1;
      #1;
      check_val("req_valid", 32'(ifu_req_valid), 32'd1);
      check_val("req_pc", ifu_req_pc, exp_pc);
      tick();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = instr;
      ifu_rsp_err   = err;
      #1;
      check_val("rsp_ready", 32'(ifu_rsp_ready), 32'd1);
      check_val("req_valid_wait", 32'(ifu_req_valid), 32'd0);
      tick();
      ifu_rsp_valid = 1'b0;
      dec_rv32      = rv32;
      pred_taken    = pt;
      bpu_op1       = op1;
      bpu_op2       = op2;
      bpu_wait      = (waits > 0);
      #1;
      check_val("dec_i_valid", 32'(dec_i_valid), 32'd1);
      check_val("dec_pc", dec_pc, exp_pc);
      check_val("dec_instr", dec_instr, instr);
      check_val("ir_valid", 32'(ir_valid), 32'd1);
      check_val("ir_pc", ir_pc, exp_pc);
      check_val("ir_instr", ir_instr, instr);
      check_val("ir_err", 32'(ir_err), 32'(err));
      for (int i = 0; i < waits; i++) begin
         bpu_wait = 1'b1;
         #1;
         check_val("stall_dec_valid", 32'(dec_i_valid), 32'd1);
         check_val("stall_req_valid", 32'(ifu_req_valid), 32'd0);
         tick();
      end
      bpu_wait = 1'b0;
      #1;
      check_val("dec_valid_release", 32'(dec_i_valid), 32'd1);
      tick();
      #1;
      check_val("dec_single_cycle", 32'(dec_i_valid), 32'd0);
      $display("fetch pc=%h instr=%h rv32=%0d taken=%0d err=%0d stalls=%0d",
               exp_pc, instr, rv32, pt, err, waits);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
      dec_rv32 = 1'b1; pred_taken = 1'b0; bpu_wait = 1'b0; bpu_op1 = '0; bpu_op2 = '0;
      ir_ready = 1'b1; pipe_flush_req = 1'b0; pipe_flush_pc = '0;

      tick();
      tick();
      check_val("rst_req_valid", 32'(ifu_req_valid), 32'd0);
      check_val("rst_req_pc", ifu_req_pc, 32'h8000_0000);
      check_val("rst_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
      check_val("rst_dec_valid", 32'(dec_i_valid), 32'd0);
      check_val("rst_ir_valid", 32'(ir_valid), 32'd0);
      check_val("rst_ir_pc", ir_pc, 32'd0);
      check_val("rst_ir_instr", ir_instr, 32'd0);
      check_val("rst_dec_pc", dec_pc, 32'd0);
      check_val("rst_ack", 32'(pipe_flush_ack), 32'd0);
      rst = 1'b0;
      #1;
      check_val("idle_req_valid", 32'(ifu_req_valid), 32'd0);
      tick();

      run_instr(32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      run_instr(32'h8000_0004, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      run_instr(32'h8000_0008, 32'h0000_006F, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FFF8, 0);
      run_instr(32'h8000_0008, 32'h0000_006F, 1'b1, 1'b1, 1'b0, 32'h8000_0101, 32'h0, 0);
      run_instr(32'h8000_0100, 32'h0000_006F, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 0);
      run_instr(32'h8000_0010, 32'h0000_4501, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      run_instr(32'h8000_0012, 32'h0000_006F, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 0);
      run_instr(32'h8000_0010, 32'h0020_0113, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2);
      run_instr(32'h8000_0014, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'h0, 0);

      // Flush raised while waiting with a full, unconsumed IR.
      ir_ready = 1'b0;
      ifu_req_ready = 1'b1;
      #1;
      check_val("req_pc_err_step", ifu_req_pc, 32'h8000_0018);
      tick();
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h1111_1111; ifu_rsp_err = 1'b0;
      tick();
      ifu_rsp_valid = 1'b0; dec_rv32 = 1'b1; pred_taken = 1'b0; bpu_wait = 1'b0;
      tick();
      ifu_req_ready = 1'b1;
      #1;
      check_val("req_pc_1c", ifu_req_pc, 32'h8000_001C);
      tick();
      ifu_req_ready = 1'b0;
      #1;
      check_val("rsp_ready_ir_full", 32'(ifu_rsp_ready), 32'd0);
      pipe_flush_req = 1'b1; pipe_flush_pc = 32'h8000_0200;
      #1;
      check_val("rsp_ready_flush", 32'(ifu_rsp_ready), 32'd1);
      check_val("ack_wait_0", 32'(pipe_flush_ack), 32'd0);
      tick();
      #1;
      check_val("ack_wait_1", 32'(pipe_flush_ack), 32'd0);
      tick();
      ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hDEAD_BEEF;
      #1;
      check_val("ack_on_rsp", 32'(pipe_flush_ack), 32'd1);
      tick();
      ifu_rsp_valid = 1'b0; pipe_flush_req = 1'b0;
      #1;
      check_val("flush_ir_valid", 32'(ir_valid), 32'd0);
      check_val("flush_ir_pc_kept", ir_pc, 32'h8000_0018);
      check_val("flush_ack_drop", 32'(pipe_flush_ack), 32'd0);
      $display("flush in WAIT_RSP to %h", pipe_flush_pc);

      // IR backpressure then simultaneous load and consume.
      ir_ready = 1'b1;
      run_instr(32'h8000_0200, 32'h0030_0193, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
      ir_ready = 1'b0; ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h2222_2222;
      tick();
      ifu_rsp_valid = 1'b0; dec_rv32 = 1'b1; pred_taken = 1'b0;
      tick();
      ifu_req_ready = 1'b1;
      #1;
      check_val("req_pc_208", ifu_req_pc, 32'h8000_0208);
      tick();
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h3333_3333;
      #1;
      check_val("bp_rsp_ready_0", 32'(ifu_rsp_ready), 32'd0);
      tick();
      #1;
      check_val("bp_rsp_ready_1", 32'(ifu_rsp_ready), 32'd0);
      check_val("bp_ir_pc_hold", ir_pc, 32'h8000_0204);
      ir_ready = 1'b1;
      #1;
      check_val("bp_rsp_ready_go", 32'(ifu_rsp_ready), 32'd1);
      tick();
      ifu_rsp_valid = 1'b0;
      #1;
      check_val("bp_ir_valid", 32'(ir_valid), 32'd1);
      check_val("bp_ir_pc_new", ir_pc, 32'h8000_0208);
      check_val("bp_ir_instr_new", ir_instr, 32'h3333_3333);
      $display("backpressure load+consume pc=%h", ir_pc);
      tick();

      // Flush in REQ while memory is ready: request must be withdrawn.
      ifu_req_ready = 1'b1; pipe_flush_req = 1'b1; pipe_flush_pc = 32'hFFFF_FFFC;
      #1;
      check_val("req_pc_20c", ifu_req_pc, 32'h8000_020C);
      check_val("flush_req_gated", 32'(ifu_req_valid), 32'd0);
      check_val("flush_req_ack", 32'(pipe_flush_ack), 32'd1);
      tick();
      pipe_flush_req = 1'b0;
      $display("flush in REQ to %h", pipe_flush_pc);
      run_instr(32'hFFFF_FFFC, 32'h0040_0213, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0);

      // Flush in DECODE while the BPU is stalling.
      ir_ready = 1'b0; ifu_req_ready = 1'b1;
      #1;
      check_val("req_pc_wrap", ifu_req_pc, 32'h0000_0000);
      tick();
      ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h4444_4444;
      tick();
      ifu_rsp_valid = 1'b0; bpu_wait = 1'b1;
      pipe_flush_req = 1'b1; pipe_flush_pc = 32'h8000_0300;
      #1;
      check_val("dec_flush_ack", 32'(pipe_flush_ack), 32'd1);
      tick();
      pipe_flush_req = 1'b0; bpu_wait = 1'b0;
      #1;
      check_val("dec_flush_pc", ifu_req_pc, 32'h8000_0300);
      check_val("dec_flush_ir_valid", 32'(ir_valid), 32'd0);
      check_val("dec_flush_dec_valid", 32'(dec_i_valid), 32'd0);
      $display("flush in DECODE to %h", pipe_flush_pc);

      // Asynchronous reset while a response is outstanding.
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      check_val("arst_req_pc", ifu_req_pc, 32'h8000_0000);
      check_val("arst_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
      check_val("arst_ir_pc", ir_pc, 32'd0);
      ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'h5555_5555;
      tick();
      rst = 1'b0;
      #1;
      check_val("arst_idle_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
      tick();
      #1;
      check_val("arst_req_rsp_ready", 32'(ifu_rsp_ready), 32'd0);
      check_val("arst_req_valid", 32'(ifu_req_valid), 32'd1);
      check_val("arst_ir_valid", 32'(ir_valid), 32'd0);
      check_val("arst_ir_instr", ir_instr, 32'd0);
      $display("async reset mid-fetch, late response ignored");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
